// File: rtl/lock_asm.sv
// Control ASM for the switch/button code-lock front panel.
// Optional feature: define AUTO_RELOCK_EN to relock OPEN after RELOCK_CYCLES idle cycles.
module lock_asm #(
  parameter logic [15:0] DEFAULT_CODE   = 16'h1234,
  parameter int unsigned MAX_TRIES      = 3,
  parameter int unsigned LOCKOUT_CYCLES = 100000000
`ifdef AUTO_RELOCK_EN
  ,
  parameter int unsigned RELOCK_CYCLES  = 500000000
`endif
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        clr,
  input  logic        ent,
  input  logic        change,
  input  logic [3:0]  sw,
  output logic [5:0]  led,
  output logic [15:0] disp_val,
  output logic [3:0]  disp_en
);

  typedef enum logic [2:0] {
    StIdle, StEnter, StCheck, StOpen, StNewCode, StLockout
  } state_e;

  localparam logic [2:0]  MaxTries = 3'(MAX_TRIES);
  localparam logic [31:0] LockLoad = 32'(LOCKOUT_CYCLES - 1);
`ifdef AUTO_RELOCK_EN
  localparam logic [31:0] RelockLast = 32'(RELOCK_CYCLES - 1);
`endif

  state_e      state_q, state_d;
  logic [15:0] code_q, code_d;
  logic [15:0] buf_q, buf_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  fail_q, fail_d;
  logic [31:0] timer_q, timer_d;
  logic [5:0]  led_q, led_d;
  logic [3:0]  disp_en_q, disp_en_d;
`ifdef AUTO_RELOCK_EN
  logic [31:0] idle_q, idle_d;
`endif

  logic [15:0] buf_shift;
  logic [2:0]  fail_inc;

  assign buf_shift = {buf_q[11:0], sw};
  assign fail_inc  = fail_q + 3'd1;

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    fail_d  = fail_q;
    timer_d = timer_q;
`ifdef AUTO_RELOCK_EN
    idle_d  = idle_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (!clr && !change && ent) begin
          buf_d   = buf_shift;
          cnt_d   = 3'd1;
          state_d = StEnter;
        end else begin
          buf_d = '0;
          cnt_d = 3'd0;
        end
      end
      StEnter: begin
        if (clr) begin
          buf_d   = '0;
          cnt_d   = 3'd0;
          state_d = StIdle;
        end else if (!change && ent) begin
          buf_d = buf_shift;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd3) state_d = StCheck;
        end
      end
      StCheck: begin
        buf_d = '0;
        cnt_d = 3'd0;
        if (buf_q == code_q) begin
          state_d = StOpen;
          fail_d  = 3'd0;
        end else begin
          fail_d = fail_inc;
          if (fail_inc == MaxTries) begin
            state_d = StLockout;
            timer_d = LockLoad;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StOpen: begin
        if (clr) begin
          state_d = StIdle;
        end else if (change) begin
          buf_d   = '0;
          cnt_d   = 3'd0;
          state_d = StNewCode;
        end
`ifdef AUTO_RELOCK_EN
        else if (ent) begin
          idle_d = '0;
        end else if (idle_q == RelockLast) begin
          state_d = StIdle;
        end else begin
          idle_d = idle_q + 32'd1;
        end
`endif
      end
      StNewCode: begin
        if (clr) begin
          buf_d   = '0;
          cnt_d   = 3'd0;
          state_d = StOpen;
        end else if (!change && ent) begin
          if (cnt_q == 3'd3) begin
            code_d  = buf_shift;
            buf_d   = '0;
            cnt_d   = 3'd0;
            state_d = StOpen;
          end else begin
            buf_d = buf_shift;
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      StLockout: begin
        if (timer_q == 32'd0) begin
          state_d = StIdle;
          fail_d  = 3'd0;
        end else begin
          timer_d = timer_q - 32'd1;
        end
      end
      default: state_d = StIdle;
    endcase
`ifdef AUTO_RELOCK_EN
    if (state_d == StOpen && state_q != StOpen) idle_d = '0;
`endif

    // Outputs are computed from next state so the registered copies line up with state_q.
    led_d = {(state_d == StOpen) || (state_d == StNewCode), state_d == StLockout,
             state_d == StNewCode, fail_d};
    if (state_d == StIdle || state_d == StEnter || state_d == StNewCode) begin
      disp_en_d = {cnt_d > 3'd3, cnt_d > 3'd2, cnt_d > 3'd1, cnt_d > 3'd0};
    end else begin
      disp_en_d = 4'd0;
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      code_q    <= DEFAULT_CODE;
      buf_q     <= '0;
      cnt_q     <= 3'd0;
      fail_q    <= 3'd0;
      timer_q   <= '0;
      led_q     <= '0;
      disp_en_q <= '0;
`ifdef AUTO_RELOCK_EN
      idle_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      buf_q     <= buf_d;
      cnt_q     <= cnt_d;
      fail_q    <= fail_d;
      timer_q   <= timer_d;
      led_q     <= led_d;
      disp_en_q <= disp_en_d;
`ifdef AUTO_RELOCK_EN
      idle_q    <= idle_d;
`endif
    end
  end

  assign led      = led_q;
  assign disp_val = buf_q;
  assign disp_en  = disp_en_q;

endmodule

// File: tb/tb_lock_asm.sv
// Self-checking bench for lock_asm: vector table, directed corner sequences, random run vs model.
module tb_lock_asm;

  localparam int MaxTries = 3;
  localparam int LockCyc  = 20;
  localparam int Relock   = 10;

  logic        clk_in = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        ent = 1'b0;
  logic        change = 1'b0;
  logic [3:0]  sw = 4'h0;
  logic [5:0]  led;
  logic [15:0] disp_val;
  logic [3:0]  disp_en;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_in = ~clk_in;

  lock_asm #(
    .DEFAULT_CODE  (16'h1234),
    .MAX_TRIES     (MaxTries),
    .LOCKOUT_CYCLES(LockCyc)
`ifdef AUTO_RELOCK_EN
    ,
    .RELOCK_CYCLES (Relock)
`endif
  ) dut (
    .clk_in  (clk_in),
    .rst     (rst),
    .clr     (clr),
    .ent     (ent),
    .change  (change),
    .sw      (sw),
    .led     (led),
    .disp_val(disp_val),
    .disp_en (disp_en)
  );

  // Behavioural model: digits typed so far, plus a few mode flags.
  logic [3:0]  m_q[$];
  logic [15:0] m_code;
  int          m_fails;
  int          m_lock;
  int          m_idle;
  bit          m_open, m_new, m_check;

  function automatic logic [15:0] pack_q();
    logic [15:0] v = 16'h0;
    foreach (m_q[i]) v = {v[11:0], m_q[i]};
    return v;
  endfunction

  function automatic logic [5:0] exp_led();
    return {m_open, m_lock > 0, m_new, 3'(m_fails)};
  endfunction

  function automatic logic [3:0] exp_en();
    int n = m_q.size();
    if ((m_open && !m_new) || m_check || m_lock > 0) return 4'h0;
    return 4'((1 << n) - 1);
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_code = 16'h1234;
    m_fails = 0;
    m_lock = 0;
    m_idle = 0;
    m_open = 0;
    m_new = 0;
    m_check = 0;
  endtask

  task automatic model_step(input logic c, input logic e, input logic ch, input logic [3:0] s);
    if (m_lock > 0) begin
      m_lock--;
      if (m_lock == 0) m_fails = 0;
    end else if (m_check) begin
      m_check = 0;
      if (pack_q() == m_code) begin
        m_open = 1;
        m_fails = 0;
        m_idle = 1;
      end else begin
        m_fails++;
        if (m_fails == MaxTries) m_lock = LockCyc;
      end
      m_q.delete();
    end else if (m_new) begin
      if (c) begin
        m_new = 0;
        m_q.delete();
        m_idle = 1;
      end else if (!ch && e) begin
        m_q.push_back(s);
        if (m_q.size() == 4) begin
          m_code = pack_q();
          m_q.delete();
          m_new = 0;
          m_idle = 1;
        end
      end
    end else if (m_open) begin
      if (c) m_open = 0;
      else if (ch) begin
        m_new = 1;
        m_q.delete();
      end
`ifdef AUTO_RELOCK_EN
      else if (e) m_idle = 1;
      else if (m_idle == Relock) m_open = 0;
      else m_idle++;
`endif
    end else begin
      if (c) m_q.delete();
      else if (!ch && e) begin
        m_q.push_back(s);
        if (m_q.size() == 4) m_check = 1;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step(input logic c, input logic e, input logic ch, input logic [3:0] s);
    clr = c;
    ent = e;
    change = ch;
    sw = s;
    @(posedge clk_in);
    model_step(c, e, ch, s);
    #1;
    clr = 1'b0;
    ent = 1'b0;
    change = 1'b0;
  endtask

  task automatic cmp_model(input string tag);
    check({tag, " led"}, 32'(led), 32'(exp_led()));
    check({tag, " disp_en"}, 32'(disp_en), 32'(exp_en()));
    check({tag, " disp_val"}, 32'(disp_val), 32'(pack_q()));
  endtask

  task automatic run(input logic c, input logic e, input logic ch, input logic [3:0] s,
                     input string tag);
    step(c, e, ch, s);
    cmp_model(tag);
  endtask

  task automatic enter_code(input logic [15:0] code, input string tag);
    for (int i = 0; i < 4; i++) run(1'b0, 1'b1, 1'b0, code[4*(3-i) +: 4], tag);
    run(1'b0, 1'b0, 1'b0, 4'h0, tag);
  endtask

  typedef struct {
    logic        c, e, ch;
    logic [3:0]  s;
    logic [5:0]  led;
    logic [3:0]  en;
    logic [15:0] val;
  } vec_t;

  vec_t tbl[19];

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 4'h1, 6'b000000, 4'b0001, 16'h0001};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 4'h2, 6'b000000, 4'b0011, 16'h0012};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 4'h3, 6'b000000, 4'b0111, 16'h0123};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 4'h4, 6'b000000, 4'b0000, 16'h1234};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 4'h0, 6'b100000, 4'b0000, 16'h0000};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 4'h7, 6'b100000, 4'b0000, 16'h0000};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 4'h0, 6'b000000, 4'b0000, 16'h0000};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 4'h5, 6'b000000, 4'b0001, 16'h0005};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 4'h6, 6'b000000, 4'b0011, 16'h0056};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 4'h7, 6'b000000, 4'b0000, 16'h0000};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 4'h8, 6'b000000, 4'b0000, 16'h0000};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 4'h0, 6'b000000, 4'b0001, 16'h0000};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 4'h0, 6'b000000, 4'b0011, 16'h0000};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 4'h0, 6'b000000, 4'b0111, 16'h0000};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 4'h0, 6'b000000, 4'b0000, 16'h0000};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 4'h0, 6'b000001, 4'b0000, 16'h0000};
    tbl[16] = '{1'b0, 1'b1, 1'b0, 4'h9, 6'b000001, 4'b0001, 16'h0009};
    tbl[17] = '{1'b0, 1'b1, 1'b1, 4'h1, 6'b000001, 4'b0001, 16'h0009};
    tbl[18] = '{1'b1, 1'b0, 1'b0, 4'h0, 6'b000001, 4'b0000, 16'h0000};

    model_reset();
    #3;
    check("reset led", 32'(led), 32'h0);
    check("reset disp_en", 32'(disp_en), 32'h0);
    check("reset disp_val", 32'(disp_val), 32'h0);
    @(posedge clk_in);
    #1;
    rst = 1'b0;

    foreach (tbl[i]) begin
      step(tbl[i].c, tbl[i].e, tbl[i].ch, tbl[i].s);
      check($sformatf("vec%0d led", i), 32'(led), 32'(tbl[i].led));
      check($sformatf("vec%0d disp_en", i), 32'(disp_en), 32'(tbl[i].en));
      check($sformatf("vec%0d disp_val", i), 32'(disp_val), 32'(tbl[i].val));
    end

    // Two more failures reach lockout; ent must be ignored throughout.
    enter_code(16'h0000, "fail2");
    check("fail2 count", 32'(led), 32'(6'b000010));
    enter_code(16'h0000, "fail3");
    check("lockout entry", 32'(led), 32'(6'b010011));
    for (int i = 1; i < LockCyc; i++) begin
      run(1'b0, 1'b1, 1'b0, 4'h5, "lockout hold");
      check("lockout led", 32'(led), 32'(6'b010011));
    end
    run(1'b0, 1'b1, 1'b0, 4'h5, "lockout exit");
    check("lockout exit led", 32'(led), 32'h0);
    check("lockout exit en", 32'(disp_en), 32'h0);

    // Change code, then only the new code opens.
    enter_code(16'h1234, "unlock");
    check("unlock led", 32'(led), 32'(6'b100000));
    run(1'b0, 1'b0, 1'b1, 4'h0, "change");
    check("newcode led", 32'(led), 32'(6'b101000));
    for (int i = 0; i < 4; i++) run(1'b0, 1'b1, 1'b0, 4'(9 + i), "newcode");
    check("newcode done led", 32'(led), 32'(6'b100000));
    run(1'b1, 1'b0, 1'b0, 4'h0, "relock");
    enter_code(16'h1234, "old code");
    check("old code led", 32'(led), 32'(6'b000001));
    enter_code(16'h9abc, "new code");
    check("new code led", 32'(led), 32'(6'b100000));
    run(1'b1, 1'b0, 1'b0, 4'h0, "relock2");

    // Reset in the middle of a lockout.
    for (int k = 0; k < MaxTries; k++) enter_code(16'h4444, "to lockout");
    for (int i = 0; i < 5; i++) run(1'b0, 1'b0, 1'b0, 4'h0, "mid lockout");
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("rst in lockout led", 32'(led), 32'h0);
    @(posedge clk_in);
    #1;
    rst = 1'b0;
    enter_code(16'h9abc, "after rst old");
    check("code reverted", 32'(led), 32'(6'b000001));
    enter_code(16'h1234, "after rst default");
    check("default opens", 32'(led), 32'(6'b100000));

`ifdef AUTO_RELOCK_EN
    for (int i = 0; i < 4; i++) run(1'b0, 1'b0, 1'b0, 4'h0, "relock wait");
    run(1'b0, 1'b1, 1'b0, 4'h3, "relock ent");
    for (int i = 0; i < Relock - 1; i++) run(1'b0, 1'b0, 1'b0, 4'h0, "relock wait2");
    check("still open before relock", 32'(led[5]), 32'h1);
    run(1'b0, 1'b0, 1'b0, 4'h0, "relock fire");
    check("auto relocked", 32'(led), 32'h0);
`else
    for (int i = 0; i < 1000; i++) step(1'b0, 1'b0, 1'b0, 4'h0);
    check("open after 1000", 32'(led), 32'(6'b100000));
    run(1'b1, 1'b0, 1'b0, 4'h0, "relock3");
`endif

    // Random pulses; sw often follows the stored code so unlocks happen.
    for (int n = 0; n < 4000; n++) begin
      logic        c, e, ch;
      logic [3:0]  s;
      logic [15:0] tmp;
      c  = ($urandom_range(0, 99) < 3);
      ch = ($urandom_range(0, 99) < 4);
      e  = ($urandom_range(0, 99) < 45);
      s  = 4'($urandom_range(0, 15));
      if (m_q.size() < 4 && $urandom_range(0, 3) != 0) begin
        tmp = m_code;
        s = tmp[4*(3-m_q.size()) +: 4];
      end
      run(c, e, ch, s, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lock_asm.md
Name: lock_asm

Overview:
- Control ASM for the switch/button code-lock front panel; sits between the debounced button pulses (ent, clr, change), the 4-bit switch bank and the LED and 7-segment display datapath.
- Collects a 4-digit hex code one digit per ent press and compares it against a stored code.
- Drives unlock, lockout and change-mode status, and allows the code to be changed while unlocked.
- Supplies the display path with the digits entered so far and a per-digit enable.

Parameters:
- DEFAULT_CODE, 16'h1234: stored code loaded at reset; digit 3 is bits [15:12], the first digit entered.
- MAX_TRIES, 3: consecutive failed checks that trigger lockout (1..7).
- LOCKOUT_CYCLES, 100000000: clk_in cycles spent in LOCKOUT (1..2^32-1).
- RELOCK_CYCLES, 500000000: idle clk_in cycles in OPEN before auto-relock; used only with AUTO_RELOCK_EN.

Ports:
- clk_in  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- clr  input  1  single-cycle pulse: clear entry / relock / abort change.
- ent  input  1  single-cycle pulse: accept sw as the next digit.
- change  input  1  single-cycle pulse: enter change-code mode (OPEN only).
- sw  input  4  digit value, sampled on the cycle ent is high.
- led  output  6  [5] unlocked, [4] lockout, [3] change mode, [2:0] failed-try count.
- disp_val  output  16  entry buffer; the newest digit is in [3:0].
- disp_en  output  4  bit i high when at least i+1 digits have been entered.

Behaviour:
- Reset (async): state=IDLE, code=DEFAULT_CODE, buffer=0, digit count=0, fail count=0, timer=0. Outputs reset to led=0, disp_val=0, disp_en=0.
- All outputs are registered or decoded from registered state only; no combinational path from any input to any output.
- Input priority within one cycle: clr > change > ent. Lower-priority pulses in the same cycle are dropped.
- ent handling (IDLE, ENTER, NEWCODE): buffer <= {buffer[11:0], sw}; count++. disp_en reflects the new count on the next cycle.
- IDLE: count=0. ent takes the first digit and moves to ENTER. change and clr are ignored apart from holding the buffer clear.
- ENTER: ent when count=3 stores the 4th digit and moves to CHECK. clr zeroes buffer and count and returns to IDLE with fail count unchanged.
- CHECK (exactly 1 cycle, ignores all inputs):
  - buffer==code: go to OPEN; fail count=0.
  - Otherwise fail count++. If the new count equals MAX_TRIES, go to LOCKOUT and load timer=LOCKOUT_CYCLES-1; else go to IDLE.
  - In both cases buffer and count are zeroed.
- OPEN: led[5]=1. clr returns to IDLE. change goes to NEWCODE with buffer and count zeroed. ent is ignored.
- NEWCODE: led[5]=1, led[3]=1. The 4th ent loads code <= {buffer[11:0], sw} and returns to OPEN, zeroing buffer and count. clr aborts to OPEN with code unchanged.
- LOCKOUT: led[4]=1; clr, ent and change are all ignored. Timer decrements each cycle. When timer=0, go to IDLE and clear fail count, so the lockout lasts exactly LOCKOUT_CYCLES cycles.
- led[2:0] = fail count in every state; it saturates at MAX_TRIES and is never exceeded.
- disp_en = 0 in OPEN, CHECK and LOCKOUT.
- rst asserted mid-entry or mid-lockout returns immediately to the reset state; the stored code reverts to DEFAULT_CODE.

Optional Feature:
- Macro: AUTO_RELOCK_EN.
- Defined: an idle counter runs only in OPEN and restarts on entering OPEN and on any ent or change pulse. After RELOCK_CYCLES cycles with no input, the block returns to IDLE. NEWCODE is never auto-relocked.
- Undefined: no idle counter logic exists; OPEN is left only by clr, change or rst.

Test Plan:
- Code entry: rst, then ent with sw=1,2,3,4 → after CHECK, led=6'b100000 and disp_en=0; then clr → IDLE, led=0.
- Lockout: MAX_TRIES=3, LOCKOUT_CYCLES=20; enter 0000 three times → led[2:0] steps 1, 2, then led=6'b010011. ent ignored for exactly 20 cycles, then led=0.
- Change code: unlock, change, ent 9,A,B,C → back in OPEN with led[3]=0; clr; entering 1234 fails (led[2:0]=1); entering 9ABC opens.
- Mid-entry clear: ent 5,6 gives disp_en=4'b0011, disp_val=16'h0056; clr and ent in the same cycle → disp_en=0, count=0, fail count unchanged.
- Reset in lockout: assert rst during LOCKOUT → same cycle led=0; the DEFAULT_CODE 1234 then opens.
- AUTO_RELOCK_EN with RELOCK_CYCLES=10: unlock with no input → IDLE after 10 cycles. An ent at cycle 5 restarts the count. Without the macro, still OPEN after 1000 cycles.
